// File: rtl/bldc_pkg.sv
// ============================================================================
// Module : bldc_pkg
// Shared Hall-sequence types, estimator FSM states and the forward-successor helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bldc_pkg;

  typedef logic [2:0] hall_state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } est_state_t;

  localparam hall_state_t HALL_INVALID_LO = 3'b000;
  localparam hall_state_t HALL_INVALID_HI = 3'b111;

  // Forward order 001->011->010->110->100->101->001; illegal codes map to 000.
  function automatic hall_state_t hall_next_fwd(input hall_state_t h);
    case (h)
      3'b001:  hall_next_fwd = 3'b011;
      3'b011:  hall_next_fwd = 3'b010;
      3'b010:  hall_next_fwd = 3'b110;
      3'b110:  hall_next_fwd = 3'b100;
      3'b100:  hall_next_fwd = 3'b101;
      3'b101:  hall_next_fwd = 3'b001;
      default: hall_next_fwd = HALL_INVALID_LO;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module : seq_divider
// Restoring divider, one quotient bit per cycle; done marks the final iteration.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_divider #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic                 busy;
  logic [CNT_W-1:0]     steps;
  logic [DIVISOR_W-1:0] rem;
  logic [DIVISOR_W-1:0] dvs;
  logic [DIVISOR_W:0]   trial;
  logic                 fits;
  logic [DIVISOR_W-1:0] diff;

  // Remainder stays below the divisor, so the difference always fits DIVISOR_W bits.
  assign trial = {rem, quotient[DIVIDEND_W-1]};
  assign fits  = trial[DIVISOR_W] | (trial[DIVISOR_W-1:0] >= dvs);
  assign diff  = trial[DIVISOR_W-1:0] - dvs;
  assign done  = busy && (steps == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      steps    <= '0;
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
    end else if (abort) begin
      busy  <= 1'b0;
      steps <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      steps    <= CNT_W'(DIVIDEND_W);
      rem      <= '0;
      dvs      <= divisor;
      quotient <= dividend;
    end else if (busy) begin
      rem      <= fits ? diff : trial[DIVISOR_W-1:0];
      quotient <= {quotient[DIVIDEND_W-2:0], fits};
      steps    <= steps - CNT_W'(1);
      busy     <= (steps != CNT_W'(1));
    end
  end

endmodule

`default_nettype wire

// File: rtl/hall_velocity_estimator.sv
// ============================================================================
// Module : hall_velocity_estimator
// Hall edge period -> velocity = VEL_SCALE / period; SIGNED_VELOCITY_EN selects signed output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hall_velocity_estimator
  import bldc_pkg::*;
#(
  parameter int                  PERIOD_W    = 24,
  parameter int                  VEL_W       = 16,
  parameter logic [31:0]         VEL_SCALE   = 32'd48_000_000,
  parameter logic [PERIOD_W-1:0] STALL_COUNT = PERIOD_W'(12_000_000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       hall,
  output logic [VEL_W-1:0] raw_velocity,
  output logic             velocity_valid,
  output logic             direction,
  output logic             stalled,
  output logic             hall_error
);

  hall_state_t         hall_meta, hs, last_hall;
  logic                armed;
  logic [PERIOD_W-1:0] counter, period, pend_period, div_divisor;
  logic                pend_valid;
  est_state_t          state;

  logic edge_seen, is_illegal, is_fwd, is_rev, accepted, skipped;
  logic at_sat, qualified, stall_now, div_start, div_done;
  logic [31:0]      quotient;
  logic [VEL_W-1:0] sample;

  always_ff @(posedge clk) begin
    hall_meta <= hall;
    hs        <= hall_meta;
  end

  assign edge_seen  = armed && (hs != last_hall);
  assign is_illegal = (hs == HALL_INVALID_LO) || (hs == HALL_INVALID_HI);
  assign is_fwd     = (hall_next_fwd(last_hall) == hs);
  assign is_rev     = (hall_next_fwd(hs) == last_hall);
  assign accepted   = edge_seen && !is_illegal && (is_fwd || is_rev);
  assign skipped    = edge_seen && !is_illegal && !(is_fwd || is_rev);
  assign at_sat     = (counter == STALL_COUNT);
  assign period     = counter + PERIOD_W'(1);
  assign qualified  = accepted && !stalled && (is_fwd == direction) && !at_sat;
  assign stall_now  = at_sat && !stalled && !accepted;

  assign div_start   = !stall_now && (((state == IDLE) && qualified) ||
                                      ((state == DONE) && (qualified || pend_valid)));
  assign div_divisor = qualified ? period : pend_period;

  seq_divider #(
    .DIVIDEND_W (32),
    .DIVISOR_W  (PERIOD_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .abort    (stall_now),
    .dividend (VEL_SCALE),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (quotient)
  );

`ifdef SIGNED_VELOCITY_EN
  logic             div_dir, pend_dir;
  logic [VEL_W-1:0] mag;
  // Magnitude capped one below 2^(VEL_W-1) so negation never produces the most negative code.
  assign mag    = (|quotient[31:VEL_W-1]) ? {1'b0, {(VEL_W-1){1'b1}}} : quotient[VEL_W-1:0];
  assign sample = div_dir ? mag : -mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_dir  <= 1'b1;
      pend_dir <= 1'b1;
    end else begin
      if (div_start) div_dir <= qualified ? is_fwd : pend_dir;
      if (qualified && (state == DIVIDE)) pend_dir <= is_fwd;
    end
  end
`else
  assign sample = (|quotient[31:VEL_W]) ? {VEL_W{1'b1}} : quotient[VEL_W-1:0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raw_velocity   <= '0;
      velocity_valid <= 1'b0;
      direction      <= 1'b1;
      stalled        <= 1'b1;
      hall_error     <= 1'b0;
      counter        <= '0;
      last_hall      <= HALL_INVALID_LO;
      armed          <= 1'b0;
      pend_valid     <= 1'b0;
      pend_period    <= '0;
      state          <= IDLE;
    end else begin
      velocity_valid <= 1'b0;
      hall_error     <= edge_seen && (is_illegal || skipped);

      if (!armed) begin
        armed     <= 1'b1;
        last_hall <= hs;
      end

      if (accepted || skipped) begin
        last_hall <= hs;
        counter   <= '0;
      end else if (!at_sat) begin
        counter <= counter + PERIOD_W'(1);
      end

      if (accepted) begin
        stalled   <= 1'b0;
        direction <= is_fwd;
      end

      if (stall_now) begin
        raw_velocity   <= '0;
        velocity_valid <= 1'b1;
        stalled        <= 1'b1;
        pend_valid     <= 1'b0;
        state          <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (qualified) state <= DIVIDE;
          end
          DIVIDE: begin
            // Newest qualified edge wins the single pending slot.
            if (qualified) begin
              pend_valid  <= 1'b1;
              pend_period <= period;
            end
            if (div_done) state <= DONE;
          end
          DONE: begin
            raw_velocity   <= sample;
            velocity_valid <= 1'b1;
            pend_valid     <= 1'b0;
            state          <= (qualified || pend_valid) ? DIVIDE : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hall_velocity_estimator.sv
// ============================================================================
// Module : tb_hall_velocity_estimator
// Randomized Hall stimulus, event-level reference model, queue scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hall_velocity_estimator;

  localparam int VW = 16;
  localparam int SCALE = 100000;
  localparam int SC = 5000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    hall = 3'b001;
  logic [VW-1:0] raw_velocity;
  logic          velocity_valid, direction, stalled, hall_error;

  hall_velocity_estimator #(
    .PERIOD_W    (24),
    .VEL_W       (VW),
    .VEL_SCALE   (32'd100000),
    .STALL_COUNT (24'd5000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .hall           (hall),
    .raw_velocity   (raw_velocity),
    .velocity_valid (velocity_valid),
    .direction      (direction),
    .stalled        (stalled),
    .hall_error     (hall_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] value;
    int            cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0, errors = 0, pcount = 0;
  int   exp_err = 0, obs_err = 0;

  int   order[6] = '{1, 3, 2, 6, 4, 5};
  int   pos = 0;
  bit   fdir = 1'b1;

  // Reference model state: sequence position, elapsed cycles, divider occupancy timeline.
  int m_h1 = 1, m_hs = 1, m_last = 0, m_cnt = 0;
  bit m_armed = 0, m_stalled = 1, m_dir = 1;
  int m_done_at = 0, m_div_period = 1, m_pend_period = 1;
  bit m_div_dir = 1, m_pend = 0, m_pend_dir = 1;
  bit snap_dir, snap_stalled;

  function automatic int pos_of(input int code);
    for (int i = 0; i < 6; i++) if (order[i] == code) return i;
    return -1;
  endfunction

  function automatic logic [VW-1:0] expect_vel(input int period, input bit dir);
    longint q;
    q = SCALE / period;
`ifdef SIGNED_VELOCITY_EN
    if (q > 32767) q = 32767;
    if (!dir) q = -q;
`else
    if (dir) q = q;
    if (q > 65535) q = 65535;
`endif
    return VW'(q);
  endfunction

  task automatic push_exp(input logic [VW-1:0] v, input int c);
    exp_t x;
    x.value = v;
    x.cyc   = c;
    sbq.push_back(x);
  endtask

  task automatic model_reset();
    m_armed = 0; m_cnt = 0; m_stalled = 1; m_dir = 1;
    m_done_at = 0; m_pend = 0;
    sbq.delete();
  endtask

  task automatic model_step(input int p, input int hs);
    bit acc, skip, qual, d, was_sat, edge_now;
    int pl, ph, period;
    acc = 0; skip = 0; qual = 0; d = 0; period = 1;
    edge_now = m_armed && (hs != m_last);
    if (!m_armed) begin
      m_armed = 1;
      m_last  = hs;
    end
    if (edge_now) begin
      if (hs == 0 || hs == 7) exp_err++;
      else begin
        pl = pos_of(m_last);
        ph = pos_of(hs);
        if (pl >= 0 && ph == (pl + 1) % 6) begin acc = 1; d = 1; end
        else if (pl >= 0 && pl == (ph + 1) % 6) begin acc = 1; d = 0; end
        else begin skip = 1; exp_err++; end
      end
    end
    was_sat = (m_cnt == SC);
    if (acc) begin
      period    = m_cnt + 1;
      qual      = !m_stalled && (d == m_dir) && !was_sat;
      m_stalled = 0;
      m_dir     = d;
    end
    if (acc || skip) begin
      m_last = hs;
      m_cnt  = 0;
    end else if (!was_sat) m_cnt++;

    if (!acc && was_sat && !m_stalled) begin
      push_exp('0, p + 1);
      m_stalled = 1;
      m_done_at = 0;
      m_pend    = 0;
    end else if (m_done_at == p) begin
      push_exp(expect_vel(m_div_period, m_div_dir), p + 1);
      if (qual) begin
        m_div_period = period; m_div_dir = d; m_done_at = p + 33;
      end else if (m_pend) begin
        m_div_period = m_pend_period; m_div_dir = m_pend_dir; m_done_at = p + 33;
      end else m_done_at = 0;
      m_pend = 0;
    end else if (m_done_at != 0) begin
      if (qual) begin m_pend = 1; m_pend_period = period; m_pend_dir = d; end
    end else if (qual) begin
      m_div_period = period; m_div_dir = d; m_done_at = p + 33;
    end
  endtask

  task automatic tick(input logic [2:0] h, input logic r);
    @(posedge clk);
    pcount++;
    snap_dir     = m_dir;
    snap_stalled = m_stalled;
    m_hs = m_h1;
    m_h1 = int'(hall);
    #1;
    hall  = h;
    reset = r;
    if (!r) model_reset();
    else model_step(pcount, m_hs);
  endtask

  task automatic hold(input int n);
    repeat (n) tick(hall, 1'b1);
  endtask

  task automatic move(input int delta, input int gap);
    if (gap > 1) hold(gap - 1);
    pos = (pos + delta + 6) % 6;
    tick(3'(order[pos]), 1'b1);
  endtask

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic check_status(input string name);
    chk({name, "_direction"}, longint'(direction), longint'(snap_dir));
    chk({name, "_stalled"}, longint'(stalled), longint'(snap_stalled));
  endtask

  always @(posedge clk) begin
    #2;
    if (hall_error) obs_err++;
    if (velocity_valid) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: value %0d at cycle %0d, none expected", raw_velocity, pcount);
      end else begin
        e = sbq.pop_front();
        if (raw_velocity !== e.value || pcount != e.cyc) begin
          errors++;
          $display("FAIL sample: got %0d at cycle %0d expected %0d at cycle %0d",
                   raw_velocity, pcount, e.value, e.cyc);
        end
      end
    end else if (sbq.size() > 0 && sbq[0].cyc <= pcount) begin
      checks++;
      errors++;
      e = sbq.pop_front();
      $display("FAIL missing_valid: expected %0d at cycle %0d, nothing by cycle %0d", e.value, e.cyc, pcount);
    end
  end

  initial begin
    int r, gap;
    repeat (5) tick(3'b001, 1'b0);
    chk("reset_raw_velocity", longint'(raw_velocity), 0);
    chk("reset_valid", longint'(velocity_valid), 0);
    chk("reset_direction", longint'(direction), 1);
    chk("reset_stalled", longint'(stalled), 1);
    chk("reset_hall_error", longint'(hall_error), 0);
    tick(3'b001, 1'b1);
    hold(20);

    // Steady forward rotation: 250-cycle period -> 400.
    repeat (8) move(1, 250);
    hold(60);
    check_status("forward");

    // Stall, then recovery: first edge silent, later edges sample.
    hold(5200);
    check_status("stall");
    repeat (3) move(1, 250);
    hold(60);

    // Reversal and reverse rotation at 500 cycles.
    move(-1, 250);
    repeat (3) move(-1, 500);
    hold(60);
    check_status("reverse");
    fdir = 1'b0;

    // Illegal code excursion, then a skipped state.
    tick(3'b111, 1'b1);
    hold(20);
    tick(3'(order[pos]), 1'b1);
    hold(30);
    move(-2, 40);
    hold(60);

    // Back-to-back samples through the pending slot, then period-1 saturation.
    repeat (5) move(-1, 10);
    repeat (3) move(-1, 1);
    hold(150);
    check_status("burst");

    for (int k = 0; k < 60; k++) begin
      r   = $urandom_range(0, 19);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : $urandom_range(41, 300);
      if (r == 0) begin
        tick(($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000, 1'b1);
        hold($urandom_range(0, 5));
        tick(3'(order[pos]), 1'b1);
        hold(gap);
      end else if (r == 1) begin
        move(fdir ? 2 : -2, gap);
      end else begin
        if (r == 2) fdir = !fdir;
        move(fdir ? 1 : -1, gap);
      end
    end
    hold(120);
    check_status("random");

    // Asynchronous reset in the middle of a divide.
    move(fdir ? 1 : -1, 100);
    move(fdir ? 1 : -1, 100);
    hold(10);
    #3 reset = 1'b0;
    #1;
    chk("async_raw_velocity", longint'(raw_velocity), 0);
    chk("async_valid", longint'(velocity_valid), 0);
    chk("async_direction", longint'(direction), 1);
    chk("async_stalled", longint'(stalled), 1);
    chk("async_hall_error", longint'(hall_error), 0);
    model_reset();
    repeat (3) tick(hall, 1'b0);
    tick(hall, 1'b1);
    hold(50);
    repeat (3) move(1, 200);
    hold(100);
    check_status("post_reset");

    chk("scoreboard_drained", sbq.size(), 0);
    chk("hall_error_count", obs_err, exp_err);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
